// File: rtl/vga_mem_pkg.sv
// -----------------------------------------------------------------------------
// vga_mem_pkg
// Shared types and default sizes for the VGA/CPU memory arbiter.
//   cpu_state_t        : CPU handshake FSM states
//   DEFAULT_ADDR_WIDTH : default address width of all arbiter ports
//   DEFAULT_DATA_WIDTH : default data width of all arbiter ports
// -----------------------------------------------------------------------------
package vga_mem_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 16;
    localparam int DEFAULT_DATA_WIDTH = 8;

    // IDLE    : waiting for a free RAM slot to issue the CPU access
    // DATA    : RAM output is valid for the issued address
    // ACK     : one-clock completion pulse to the CPU
    // RELEASE : waiting for the CPU to drop its request
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DATA    = 2'd1,
        ACK     = 2'd2,
        RELEASE = 2'd3
    } cpu_state_t;

endpackage

// File: rtl/vga_mem_arbiter.sv
// -----------------------------------------------------------------------------
// vga_mem_arbiter
// Shares one synchronous single-port RAM between the VGA fetch master and the
// CPU bus. VGA cycles are announced one clock ahead and always win; the CPU is
// stalled around them and completes with a registered one-clock ack.
//
// Ports:
//   i_clk, i_reset_n          clock, asynchronous active-low reset
//   i_vga_addr/cs/access      VGA fetch address, cycle strobe, next-clock claim
//   o_vga_dat                 VGA read data (combinational copy of i_mem_dat)
//   i_cpu_addr/dat/cs/we      CPU request, held until o_cpu_ack
//   o_cpu_dat, o_cpu_ack      registered CPU read data and completion pulse
//   o_mem_addr/dat/cs/we      RAM control, i_mem_dat RAM read data (1-clk lat.)
//   o_proto_err               sticky: VGA cycle seen without an announcement
// -----------------------------------------------------------------------------
module vga_mem_arbiter
    import vga_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [ADDR_WIDTH-1:0] i_vga_addr,
    input  logic                  i_vga_cs,
    input  logic                  i_vga_access,
    output logic [DATA_WIDTH-1:0] o_vga_dat,
    input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
    input  logic [DATA_WIDTH-1:0] i_cpu_dat,
    input  logic                  i_cpu_cs,
    input  logic                  i_cpu_we,
    output logic [DATA_WIDTH-1:0] o_cpu_dat,
    output logic                  o_cpu_ack,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_dat,
    input  logic [DATA_WIDTH-1:0] i_mem_dat,
    output logic                  o_mem_cs,
    output logic                  o_mem_we,
    output logic                  o_proto_err
);

    cpu_state_t            state;
    cpu_state_t            state_next;
    logic                  r_vga_grant;
    logic                  r_active;
    logic                  r_proto_err;
    logic                  r_is_read;
    logic                  r_cpu_ack;
    logic [DATA_WIDTH-1:0] r_cpu_dat;
    logic                  cpu_issue;

    // The RAM output belongs to whoever addressed it last clock; VGA just
    // takes it straight through.
    assign o_vga_dat   = i_mem_dat;
    assign o_cpu_dat   = r_cpu_dat;
    assign o_cpu_ack   = r_cpu_ack;
    assign o_proto_err = r_proto_err;

    // The CPU may only use a clock that is neither reserved by last clock's
    // announcement nor claimed by a live VGA strobe, and never in the first
    // clock after reset release.
    assign cpu_issue = (state == IDLE) && i_cpu_cs && !r_vga_grant
                       && !i_vga_cs && r_active;

    // Reservation register, post-reset enable and the sticky protocol flag.
    // The flag catches VGA strobes that were not announced the clock before.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_vga_grant <= 1'b0;
            r_active    <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_vga_grant <= i_vga_access;
            r_active    <= 1'b1;
            if (i_vga_cs && !r_vga_grant) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    // CPU FSM state register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // CPU FSM next-state logic. RELEASE holds until the CPU lets go so that a
    // request still asserted after its ack is never serviced twice.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cpu_issue) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                state_next = ACK;
            end
            ACK: begin
                state_next = RELEASE;
            end
            RELEASE: begin
                if (!i_cpu_cs) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // CPU datapath: remember the direction at issue, capture read data while
    // the RAM presents it, and raise ack for exactly the clock spent in ACK.
    // Writes leave the last read value on o_cpu_dat.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_is_read <= 1'b0;
            r_cpu_dat <= '0;
            r_cpu_ack <= 1'b0;
        end else begin
            if (cpu_issue) begin
                r_is_read <= !i_cpu_we;
            end
            if ((state == DATA) && r_is_read) begin
                r_cpu_dat <= i_mem_dat;
            end
            r_cpu_ack <= (state == DATA);
        end
    end

    // RAM port mux. VGA strobe first, then a CPU issue cycle, otherwise idle.
    // Everything stays at zero until the clock after reset release.
    always_comb begin
        o_mem_addr = '0;
        o_mem_dat  = '0;
        o_mem_cs   = 1'b0;
        o_mem_we   = 1'b0;
        if (r_active) begin
            if (i_vga_cs) begin
                o_mem_addr = i_vga_addr;
                o_mem_cs   = 1'b1;
            end else if (cpu_issue) begin
                o_mem_addr = i_cpu_addr;
                o_mem_dat  = i_cpu_dat;
                o_mem_we   = i_cpu_we;
                o_mem_cs   = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vga_mem_arbiter
// Directed self-checking bench for vga_mem_arbiter with a behavioural
// synchronous single-port RAM (read data one clock after the address cycle).
// Inputs change on the falling edge; outputs are checked 1 ns later.
// -----------------------------------------------------------------------------
module tb_vga_mem_arbiter;
    import vga_mem_pkg::*;

    logic        i_clk;
    logic        i_reset_n;
    logic [15:0] i_vga_addr;
    logic        i_vga_cs;
    logic        i_vga_access;
    logic [7:0]  o_vga_dat;
    logic [15:0] i_cpu_addr;
    logic [7:0]  i_cpu_dat;
    logic        i_cpu_cs;
    logic        i_cpu_we;
    logic [7:0]  o_cpu_dat;
    logic        o_cpu_ack;
    logic [15:0] o_mem_addr;
    logic [7:0]  o_mem_dat;
    logic [7:0]  i_mem_dat;
    logic        o_mem_cs;
    logic        o_mem_we;
    logic        o_proto_err;

    logic [7:0]  ram [0:65535];
    logic        load_en;
    logic [15:0] load_addr;
    logic [7:0]  load_dat;

    int total = 0;
    int bad = 0;
    int ack_count = 0;

    vga_mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_vga_addr   (i_vga_addr),
        .i_vga_cs     (i_vga_cs),
        .i_vga_access (i_vga_access),
        .o_vga_dat    (o_vga_dat),
        .i_cpu_addr   (i_cpu_addr),
        .i_cpu_dat    (i_cpu_dat),
        .i_cpu_cs     (i_cpu_cs),
        .i_cpu_we     (i_cpu_we),
        .o_cpu_dat    (o_cpu_dat),
        .o_cpu_ack    (o_cpu_ack),
        .o_mem_addr   (o_mem_addr),
        .o_mem_dat    (o_mem_dat),
        .i_mem_dat    (i_mem_dat),
        .o_mem_cs     (o_mem_cs),
        .o_mem_we     (o_mem_we),
        .o_proto_err  (o_proto_err)
    );

    // Free-running clock, 10 ns period.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Behavioural RAM with a preload port used only while the DUT is in reset.
    always @(posedge i_clk) begin
        if (load_en) begin
            ram[load_addr] <= load_dat;
        end else if (o_mem_cs) begin
            if (o_mem_we) begin
                ram[o_mem_addr] <= o_mem_dat;
            end
            i_mem_dat <= ram[o_mem_addr];
        end
    end

    // Independent count of ack pulses, compared against the number of
    // transactions the stimulus expects to complete.
    always @(posedge i_clk) begin
        if (o_cpu_ack) begin
            ack_count <= ack_count + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Drive one clock's worth of inputs on the falling edge, then settle.
    task automatic applyStimulus(input logic acc, input logic vcs, input logic [15:0] vaddr,
                                 input logic ccs, input logic cwe, input logic [15:0] caddr,
                                 input logic [7:0] cdat);
        @(negedge i_clk);
        i_vga_access = acc;
        i_vga_cs     = vcs;
        i_vga_addr   = vaddr;
        i_cpu_cs     = ccs;
        i_cpu_we     = cwe;
        i_cpu_addr   = caddr;
        i_cpu_dat    = cdat;
        #1;
    endtask

    task automatic loadRam(input logic [15:0] addr, input logic [7:0] dat);
        @(negedge i_clk);
        load_en   = 1'b1;
        load_addr = addr;
        load_dat  = dat;
    endtask

    logic [15:0] t6_addr [4];
    logic [7:0]  t6_dat  [4];
    logic        t6_we   [4];
    logic [7:0]  exp_cpu_dat;

    initial begin
        i_reset_n    = 1'b0;
        i_vga_access = 1'b0;
        i_vga_cs     = 1'b0;
        i_vga_addr   = '0;
        i_cpu_cs     = 1'b0;
        i_cpu_we     = 1'b0;
        i_cpu_addr   = '0;
        i_cpu_dat    = '0;
        i_mem_dat    = '0;
        load_en      = 1'b0;
        load_addr    = '0;
        load_dat     = '0;

        loadRam(16'h0010, 8'h3C);
        loadRam(16'h1234, 8'hA5);
        loadRam(16'h4000, 8'hC3);
        loadRam(16'h4001, 8'h96);
        loadRam(16'h5000, 8'h22);
        loadRam(16'h0040, 8'h11);
        @(negedge i_clk);
        load_en = 1'b0;

        // Reset values, with a CPU read already requested.
        applyStimulus(0, 0, 16'h0, 1, 0, 16'h0010, 8'h00);
        checkOutput("rst ack", o_cpu_ack, 0);
        checkOutput("rst mem_cs", o_mem_cs, 0);
        checkOutput("rst mem_addr", o_mem_addr, 0);
        checkOutput("rst cpu_dat", o_cpu_dat, 0);
        checkOutput("rst proto_err", o_proto_err, 0);

        // T1: release reset with the request held.
        @(negedge i_clk);
        i_reset_n = 1'b1;
        #1;
        checkOutput("t1 first clk mem_cs", o_mem_cs, 0);
        applyStimulus(0, 0, 16'h0, 1, 0, 16'h0010, 8'h00);
        checkOutput("t1 issue mem_cs", o_mem_cs, 1);
        checkOutput("t1 issue addr", o_mem_addr, 16'h0010);
        checkOutput("t1 issue we", o_mem_we, 0);
        applyStimulus(0, 0, 16'h0, 1, 0, 16'h0010, 8'h00);
        checkOutput("t1 data mem_cs", o_mem_cs, 0);
        checkOutput("t1 data ack", o_cpu_ack, 0);
        applyStimulus(0, 0, 16'h0, 1, 0, 16'h0010, 8'h00);
        checkOutput("t1 ack", o_cpu_ack, 1);
        checkOutput("t1 cpu_dat", o_cpu_dat, 8'h3C);
        applyStimulus(0, 0, 16'h0, 0, 0, 16'h0, 8'h00);
        checkOutput("t1 ack low", o_cpu_ack, 0);

        // T2: read 0x1234 on an idle bus, request held past the ack.
        applyStimulus(0, 0, 16'h0, 1, 0, 16'h1234, 8'h00);
        checkOutput("t2 issue mem_cs", o_mem_cs, 1);
        checkOutput("t2 issue addr", o_mem_addr, 16'h1234);
        applyStimulus(0, 0, 16'h0, 1, 0, 16'h1234, 8'h00);
        checkOutput("t2 data ack", o_cpu_ack, 0);
        applyStimulus(0, 0, 16'h0, 1, 0, 16'h1234, 8'h00);
        checkOutput("t2 ack", o_cpu_ack, 1);
        checkOutput("t2 cpu_dat", o_cpu_dat, 8'hA5);
        applyStimulus(0, 0, 16'h0, 1, 0, 16'h1234, 8'h00);
        checkOutput("t2 single pulse", o_cpu_ack, 0);
        applyStimulus(0, 0, 16'h0, 1, 0, 16'h1234, 8'h00);
        checkOutput("t2 no reissue", o_mem_cs, 0);
        checkOutput("t2 ack held low", o_cpu_ack, 0);
        applyStimulus(0, 0, 16'h0, 0, 0, 16'h0, 8'h00);

        // T3: one VGA character, announce at x=3/x=5, strobes at x=4/x=6.
        // The CPU write shows up during the x=4 VGA cycle and issues at x=5.
        applyStimulus(0, 0, 16'h0, 0, 0, 16'h0, 8'h00);   // x=0
        applyStimulus(0, 0, 16'h0, 0, 0, 16'h0, 8'h00);   // x=1
        applyStimulus(0, 0, 16'h0, 0, 0, 16'h0, 8'h00);   // x=2
        applyStimulus(1, 0, 16'h0, 0, 0, 16'h0, 8'h00);   // x=3
        checkOutput("t3 x3 mem_cs", o_mem_cs, 0);
        applyStimulus(0, 1, 16'h4000, 1, 1, 16'h2000, 8'h5A); // x=4
        checkOutput("t3 x4 vga addr", o_mem_addr, 16'h4000);
        checkOutput("t3 x4 we", o_mem_we, 0);
        checkOutput("t3 x4 cs", o_mem_cs, 1);
        applyStimulus(1, 0, 16'h0, 1, 1, 16'h2000, 8'h5A);    // x=5
        checkOutput("t3 x5 vga dat", o_vga_dat, 8'hC3);
        checkOutput("t3 x5 cpu addr", o_mem_addr, 16'h2000);
        checkOutput("t3 x5 we", o_mem_we, 1);
        checkOutput("t3 x5 wdat", o_mem_dat, 8'h5A);
        applyStimulus(0, 1, 16'h4001, 1, 1, 16'h2000, 8'h5A); // x=6
        checkOutput("t3 x6 vga addr", o_mem_addr, 16'h4001);
        checkOutput("t3 x6 we", o_mem_we, 0);
        applyStimulus(0, 0, 16'h0, 1, 1, 16'h2000, 8'h5A);    // x=7
        checkOutput("t3 x7 ack", o_cpu_ack, 1);
        checkOutput("t3 x7 vga dat", o_vga_dat, 8'h96);
        checkOutput("t3 write keeps cpu_dat", o_cpu_dat, 8'hA5);
        checkOutput("t3 ram", ram[16'h2000], 8'h5A);
        checkOutput("t3 proto_err", o_proto_err, 0);
        applyStimulus(0, 0, 16'h0, 0, 0, 16'h0, 8'h00);

        // T3b: an announced clock with no VGA strobe still blocks the CPU.
        applyStimulus(1, 0, 16'h0, 0, 0, 16'h0, 8'h00);
        applyStimulus(0, 0, 16'h0, 1, 0, 16'h0010, 8'h00);
        checkOutput("t3b stall on grant", o_mem_cs, 0);
        applyStimulus(0, 0, 16'h0, 1, 0, 16'h0010, 8'h00);
        checkOutput("t3b issue addr", o_mem_addr, 16'h0010);
        checkOutput("t3b issue cs", o_mem_cs, 1);
        applyStimulus(0, 0, 16'h0, 1, 0, 16'h0010, 8'h00);
        applyStimulus(0, 0, 16'h0, 1, 0, 16'h0010, 8'h00);
        checkOutput("t3b ack", o_cpu_ack, 1);
        checkOutput("t3b cpu_dat", o_cpu_dat, 8'h3C);
        applyStimulus(0, 0, 16'h0, 0, 0, 16'h0, 8'h00);

        // T4: unannounced VGA strobe together with a CPU request.
        applyStimulus(0, 1, 16'h5000, 1, 0, 16'h1234, 8'h00);
        checkOutput("t4 vga addr", o_mem_addr, 16'h5000);
        checkOutput("t4 vga we", o_mem_we, 0);
        checkOutput("t4 vga cs", o_mem_cs, 1);
        applyStimulus(0, 0, 16'h0, 1, 0, 16'h1234, 8'h00);
        checkOutput("t4 proto_err set", o_proto_err, 1);
        checkOutput("t4 vga dat", o_vga_dat, 8'h22);
        checkOutput("t4 cpu issue addr", o_mem_addr, 16'h1234);
        applyStimulus(0, 0, 16'h0, 1, 0, 16'h1234, 8'h00);
        applyStimulus(0, 0, 16'h0, 1, 0, 16'h1234, 8'h00);
        checkOutput("t4 ack", o_cpu_ack, 1);
        applyStimulus(0, 0, 16'h0, 0, 0, 16'h0, 8'h00);
        applyStimulus(0, 0, 16'h0, 0, 0, 16'h0, 8'h00);
        checkOutput("t4 proto_err sticky", o_proto_err, 1);

        // T5: reset pulse while a read sits in DATA.
        applyStimulus(0, 0, 16'h0, 1, 0, 16'h0040, 8'h00);
        applyStimulus(0, 0, 16'h0, 1, 0, 16'h0040, 8'h00);
        i_reset_n = 1'b0;
        #1;
        checkOutput("t5 rst ack", o_cpu_ack, 0);
        checkOutput("t5 rst cpu_dat", o_cpu_dat, 0);
        checkOutput("t5 rst proto_err", o_proto_err, 0);
        applyStimulus(0, 0, 16'h0, 1, 0, 16'h0040, 8'h00);
        checkOutput("t5 in rst ack", o_cpu_ack, 0);
        checkOutput("t5 in rst mem_cs", o_mem_cs, 0);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        i_cpu_cs  = 1'b0;
        #1;
        checkOutput("t5 release mem_cs", o_mem_cs, 0);
        applyStimulus(0, 0, 16'h0, 0, 0, 16'h0, 8'h00);
        checkOutput("t5 no ack", o_cpu_ack, 0);
        applyStimulus(0, 0, 16'h0, 1, 0, 16'h0040, 8'h00);
        checkOutput("t5 reissue cs", o_mem_cs, 1);
        applyStimulus(0, 0, 16'h0, 1, 0, 16'h0040, 8'h00);
        applyStimulus(0, 0, 16'h0, 1, 0, 16'h0040, 8'h00);
        checkOutput("t5 ack", o_cpu_ack, 1);
        checkOutput("t5 cpu_dat", o_cpu_dat, 8'h11);
        applyStimulus(0, 0, 16'h0, 0, 0, 16'h0, 8'h00);

        // T6: back-to-back requests, cs dropped one clock after each ack.
        t6_we[0] = 1'b1; t6_addr[0] = 16'h0100; t6_dat[0] = 8'h77;
        t6_we[1] = 1'b0; t6_addr[1] = 16'h0100; t6_dat[1] = 8'h77;
        t6_we[2] = 1'b0; t6_addr[2] = 16'h1234; t6_dat[2] = 8'hA5;
        t6_we[3] = 1'b1; t6_addr[3] = 16'h0101; t6_dat[3] = 8'h0F;
        exp_cpu_dat = 8'h11;
        for (int i = 0; i < 4; i++) begin
            if (!t6_we[i]) begin
                exp_cpu_dat = t6_dat[i];
            end
            applyStimulus(0, 0, 16'h0, 1, t6_we[i], t6_addr[i], t6_dat[i]);
            checkOutput("t6 issue cs", o_mem_cs, 1);
            checkOutput("t6 issue we", o_mem_we, t6_we[i]);
            applyStimulus(0, 0, 16'h0, 1, t6_we[i], t6_addr[i], t6_dat[i]);
            applyStimulus(0, 0, 16'h0, 1, t6_we[i], t6_addr[i], t6_dat[i]);
            checkOutput("t6 ack", o_cpu_ack, 1);
            checkOutput("t6 cpu_dat", o_cpu_dat, exp_cpu_dat);
            applyStimulus(0, 0, 16'h0, 0, 0, 16'h0, 8'h00);
            checkOutput("t6 ack low", o_cpu_ack, 0);
        end
        checkOutput("t6 ram 0101", ram[16'h0101], 8'h0F);

        applyStimulus(0, 0, 16'h0, 0, 0, 16'h0, 8'h00);
        checkOutput("ack count", ack_count, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
